// File: rtl/dcu_fill_seq_pkg.sv
// Shared types and constants for the D-cache fill sequencer.
// Optional parity output is enabled with `define DCU_FILL_PARITY_EN.
`ifndef DCU_FILL_SEQ_PKG_SV
`define DCU_FILL_SEQ_PKG_SV

// Line index of a byte address: drops the 4-byte word and 2-bit word offset.
`define DCU_FILL_LINE_IDX(addr, idx_w) addr[(idx_w)+1:4]

package dcu_fill_seq_pkg;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned WORD_OFF_W     = 2;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_WAIT_ACK = 5'b00010,
    S_FILL     = 5'b00100,
    S_ZERO     = 5'b01000,
    S_ERR      = 5'b10000
  } fill_state_e;

  // Even parity per byte: each bit makes its byte plus parity have an even count of ones.
  function automatic logic [3:0] byte_parity(input logic [31:0] d);
    logic [3:0] p;
    for (int unsigned i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

endpackage

`endif

// File: rtl/dcu_fill_seq_if.sv
// Handshake/data bundle between the miss controller, memory return path and cache array.
// fill_wr_par exists only when DCU_FILL_PARITY_EN is defined.
interface dcu_fill_seq_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 10
);
  logic              miss_start;
  logic              zero_start;
  logic [ADDR_W-1:0] req_addr;
  logic              nc_xaction;
  logic              normal_ack;
  logic              error_ack;
  logic [31:0]       mem_data;
  logic              fill_wr_en;
  logic [IDX_W-1:0]  fill_wr_addr;
  logic [31:0]       fill_wr_data;
  logic              crit_vld;
  logic [31:0]       crit_data;
  logic              line_done;
  logic              fill_err;
  logic              fill_busy;
`ifdef DCU_FILL_PARITY_EN
  logic [3:0]        fill_wr_par;
`endif

  modport master (
    output miss_start, zero_start, req_addr, nc_xaction, normal_ack, error_ack, mem_data,
    input  fill_wr_en, fill_wr_addr, fill_wr_data, crit_vld, crit_data, line_done,
           fill_err, fill_busy
`ifdef DCU_FILL_PARITY_EN
    , input fill_wr_par
`endif
  );

  modport slave (
    input  miss_start, zero_start, req_addr, nc_xaction, normal_ack, error_ack, mem_data,
    output fill_wr_en, fill_wr_addr, fill_wr_data, crit_vld, crit_data, line_done,
           fill_err, fill_busy
`ifdef DCU_FILL_PARITY_EN
    , output fill_wr_par
`endif
  );
endinterface

// File: rtl/dcu_fill_ctr.sv
// Word counter for a line fill plus the critical-word-first wrap adder.
module dcu_fill_ctr
  import dcu_fill_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [WORD_OFF_W-1:0] base,
  output logic [WORD_OFF_W-1:0] cnt,
  output logic [WORD_OFF_W-1:0] off
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  // 2-bit add wraps naturally, giving the critical-word-first order.
  always_comb off = base + cnt;

endmodule

// File: rtl/dcu_fill_seq.sv
// D-cache fill sequencer: critical-word-first line fills, zeroline fills and error abort.
// Optional per-byte write parity enabled by `define DCU_FILL_PARITY_EN.
module dcu_fill_seq
  import dcu_fill_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 10
) (
  input logic          clk,
  input logic          reset,
  dcu_fill_seq_if.slave bus
);

  fill_state_e            state, state_n;
  logic [IDX_W-3:0]       line_idx;
  logic [WORD_OFF_W-1:0]  crit_wd;
  logic                   nc;
  logic [WORD_OFF_W-1:0]  cnt, off;
  logic                   ctr_clr, ctr_inc;
  logic                   lat_miss, lat_zero;

  logic                   wr_en_n, crit_vld_n, done_n, err_n;
  logic [31:0]            wr_data_n, crit_data_n;

  dcu_fill_ctr u_ctr (
    .clk  (clk),
    .rst  (reset),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .base (crit_wd),
    .cnt  (cnt),
    .off  (off)
  );

  always_comb begin
    state_n     = state;
    wr_en_n     = 1'b0;
    wr_data_n   = '0;
    crit_vld_n  = 1'b0;
    crit_data_n = '0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
    lat_miss    = 1'b0;
    lat_zero    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.miss_start) begin
          state_n  = S_WAIT_ACK;
          lat_miss = 1'b1;
          ctr_clr  = 1'b1;
        end else if (bus.zero_start) begin
          state_n  = S_ZERO;
          lat_zero = 1'b1;
          ctr_clr  = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (bus.normal_ack) begin
          crit_vld_n  = 1'b1;
          crit_data_n = bus.mem_data;
          if (nc) begin
            state_n = S_IDLE;
          end else begin
            wr_en_n   = 1'b1;
            wr_data_n = bus.mem_data;
            ctr_inc   = 1'b1;
            state_n   = S_FILL;
          end
        end else if (bus.error_ack) begin
          err_n   = 1'b1;
          state_n = S_ERR;
        end
      end
      S_FILL: begin
        if (bus.normal_ack) begin
          wr_en_n   = 1'b1;
          wr_data_n = bus.mem_data;
          ctr_inc   = 1'b1;
          if (cnt == 2'(WORDS_PER_LINE - 1)) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end else if (bus.error_ack) begin
          err_n   = 1'b1;
          state_n = S_ERR;
        end
      end
      S_ZERO: begin
        wr_en_n = 1'b1;
        ctr_inc = 1'b1;
        if (cnt == 2'(WORDS_PER_LINE - 1)) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // crit_wd is forced to 0 for zerolines so the same adder yields offsets 0..3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      line_idx <= '0;
      crit_wd  <= '0;
      nc       <= 1'b0;
    end else begin
      state <= state_n;
      if (lat_miss) begin
        line_idx <= `DCU_FILL_LINE_IDX(bus.req_addr, IDX_W);
        crit_wd  <= bus.req_addr[3:2];
        nc       <= bus.nc_xaction;
      end else if (lat_zero) begin
        line_idx <= `DCU_FILL_LINE_IDX(bus.req_addr, IDX_W);
        crit_wd  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.fill_wr_en   <= 1'b0;
      bus.fill_wr_addr <= '0;
      bus.fill_wr_data <= '0;
      bus.crit_vld     <= 1'b0;
      bus.crit_data    <= '0;
      bus.line_done    <= 1'b0;
      bus.fill_err     <= 1'b0;
      bus.fill_busy    <= 1'b0;
    end else begin
      bus.fill_wr_en   <= wr_en_n;
      bus.fill_wr_addr <= wr_en_n ? {line_idx, off} : '0;
      bus.fill_wr_data <= wr_data_n;
      bus.crit_vld     <= crit_vld_n;
      bus.crit_data    <= crit_data_n;
      bus.line_done    <= done_n;
      bus.fill_err     <= err_n;
      bus.fill_busy    <= (state_n != S_IDLE);
    end
  end

`ifdef DCU_FILL_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.fill_wr_par <= '0;
    else       bus.fill_wr_par <= byte_parity(wr_data_n);
  end
`endif

endmodule

// File: tb/tb_dcu_fill_seq.sv
// Directed-plus-random bench for dcu_fill_seq with a line-level expected-write model.
module tb_dcu_fill_seq;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned total = 0;
  int unsigned bad = 0;

  dcu_fill_seq_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus_if ();

  dcu_fill_seq #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a >> 4) & ((32'd1 << (IDX_W - 2)) - 1);
  endfunction

  function automatic logic [3:0] par_of(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wr_en"}, bus_if.fill_wr_en, 0);
    chk({tag, "_crit"}, bus_if.crit_vld, 0);
    chk({tag, "_done"}, bus_if.line_done, 0);
    chk({tag, "_err"}, bus_if.fill_err, 0);
  endtask

  // Expected write for ack i of a miss: line base plus (critical word + i) mod 4.
  task automatic do_miss(input logic [31:0] addr, input bit nc, input int nacks,
                         input bit end_err, input bit also_zero);
    int unsigned line = line_of(addr);
    int unsigned c = (addr >> 2) % 4;
    logic [31:0] d;
    bus_if.req_addr   = addr;
    bus_if.nc_xaction = nc;
    bus_if.miss_start = 1'b1;
    bus_if.zero_start = also_zero;
    step();
    bus_if.miss_start = 1'b0;
    bus_if.zero_start = 1'b0;
    bus_if.nc_xaction = $urandom_range(0, 1);
    bus_if.req_addr   = $urandom;
    chk("start_busy", bus_if.fill_busy, 1);
    chk("start_wr_en", bus_if.fill_wr_en, 0);
    for (int i = 0; i < nacks; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus_if.miss_start = 1'b1;
        bus_if.zero_start = $urandom_range(0, 1);
        step();
        bus_if.miss_start = 1'b0;
        bus_if.zero_start = 1'b0;
        chk_quiet("gap");
        chk("gap_busy", bus_if.fill_busy, 1);
      end
      d = $urandom;
      bus_if.mem_data   = d;
      bus_if.normal_ack = 1'b1;
      bus_if.error_ack  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      bus_if.normal_ack = 1'b0;
      bus_if.error_ack  = 1'b0;
      chk("ack_crit_vld", bus_if.crit_vld, (i == 0) ? 1 : 0);
      if (i == 0) chk("ack_crit_data", bus_if.crit_data, d);
      chk("ack_err", bus_if.fill_err, 0);
      if (nc) begin
        chk("nc_wr_en", bus_if.fill_wr_en, 0);
        chk("nc_busy", bus_if.fill_busy, 0);
        return;
      end
      chk("ack_wr_en", bus_if.fill_wr_en, 1);
      chk("ack_wr_addr", 32'(bus_if.fill_wr_addr), (line << 2) | ((c + i) % 4));
      chk("ack_wr_data", bus_if.fill_wr_data, d);
      chk("ack_done", bus_if.line_done, (i == 3) ? 1 : 0);
      chk("ack_busy", bus_if.fill_busy, (i == 3) ? 0 : 1);
`ifdef DCU_FILL_PARITY_EN
      chk("ack_par", 32'(bus_if.fill_wr_par), 32'(par_of(d)));
`endif
    end
    if (end_err) begin
      bus_if.error_ack = 1'b1;
      step();
      bus_if.error_ack = 1'b0;
      chk("err_pulse", bus_if.fill_err, 1);
      chk("err_wr_en", bus_if.fill_wr_en, 0);
      chk("err_done", bus_if.line_done, 0);
      step();
      chk("err_after", bus_if.fill_err, 0);
      chk("err_busy", bus_if.fill_busy, 0);
      chk("err_done2", bus_if.line_done, 0);
    end else begin
      step();
      chk_quiet("post");
      chk("post_busy", bus_if.fill_busy, 0);
    end
  endtask

  task automatic do_zero(input logic [31:0] addr);
    int unsigned line = line_of(addr);
    bus_if.req_addr   = addr;
    bus_if.zero_start = 1'b1;
    step();
    bus_if.zero_start = 1'b0;
    chk("z_busy", bus_if.fill_busy, 1);
    chk("z_wr_en0", bus_if.fill_wr_en, 0);
    for (int i = 0; i < 4; i++) begin
      bus_if.normal_ack = $urandom_range(0, 1);
      bus_if.error_ack  = $urandom_range(0, 1);
      bus_if.mem_data   = $urandom;
      step();
      chk("z_wr_en", bus_if.fill_wr_en, 1);
      chk("z_wr_addr", 32'(bus_if.fill_wr_addr), (line << 2) | i);
      chk("z_wr_data", bus_if.fill_wr_data, 0);
      chk("z_done", bus_if.line_done, (i == 3) ? 1 : 0);
      chk("z_err", bus_if.fill_err, 0);
      chk("z_crit", bus_if.crit_vld, 0);
      chk("z_busy_i", bus_if.fill_busy, (i == 3) ? 0 : 1);
`ifdef DCU_FILL_PARITY_EN
      chk("z_par", 32'(bus_if.fill_wr_par), 0);
`endif
    end
    bus_if.normal_ack = 1'b0;
    bus_if.error_ack  = 1'b0;
    step();
    chk_quiet("z_post");
    chk("z_post_busy", bus_if.fill_busy, 0);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    bus_if.miss_start = 1'b0;
    bus_if.zero_start = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.nc_xaction = 1'b0;
    bus_if.normal_ack = 1'b0;
    bus_if.error_ack  = 1'b0;
    bus_if.mem_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("rst");
    chk("rst_busy", bus_if.fill_busy, 0);
    chk("rst_addr", 32'(bus_if.fill_wr_addr), 0);
    chk("rst_data", bus_if.fill_wr_data, 0);
    reset = 1'b0;

    do_miss(32'h0000_1238, 1'b0, 4, 1'b0, 1'b0);
    do_miss(32'h0000_2004, 1'b1, 1, 1'b0, 1'b0);
    do_miss(32'h0000_0ABC, 1'b0, 2, 1'b1, 1'b0);
    do_miss(32'h0000_3330, 1'b0, 0, 1'b1, 1'b0);
    do_miss(32'h0000_0F0C, 1'b0, 4, 1'b0, 1'b1);
    do_zero(32'h0000_0040);

    // Asynchronous reset in the middle of a fill.
    bus_if.req_addr   = 32'h0000_5678;
    bus_if.nc_xaction = 1'b0;
    bus_if.miss_start = 1'b1;
    step();
    bus_if.miss_start = 1'b0;
    bus_if.mem_data   = $urandom;
    bus_if.normal_ack = 1'b1;
    step();
    bus_if.normal_ack = 1'b0;
    chk("pre_rst_wr_en", bus_if.fill_wr_en, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_quiet("arst");
    chk("arst_busy", bus_if.fill_busy, 0);
    step();
    chk_quiet("arst_hold");
    reset = 1'b0;
    do_miss(32'h0000_1234, 1'b0, 4, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      a = $urandom;
      n = $urandom_range(0, 3);
      case (n)
        0: do_miss(a, 1'b1, 1, 1'b0, 1'($urandom_range(0, 1)));
        1: do_miss(a, 1'b0, $urandom_range(0, 3), 1'b1, 1'b0);
        2: do_zero(a);
        default: do_miss(a, 1'b0, 4, 1'b0, 1'($urandom_range(0, 1)));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
